// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, FSM state encodings and ALU operation codes
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        IMM_EXEC  = 4'd10,
        IMM_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [1:0] ALU_ADD      = 2'b00;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_R_FORMAT = 2'b10;
    localparam logic [1:0] ALU_ORI      = 2'b11;

    // First state after DECODE; FETCH marks an unsupported opcode
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:       return EXECUTE;
            OP_LW, OP_SW:   return MEM_ADDR;
            OP_BEQ:         return BRANCH;
            OP_J:           return JUMP;
            OP_ADDI, OP_ORI: return IMM_EXEC;
            default:        return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       zero_ext,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t cur_state, next_state;

    assign state = cur_state;

    // State register; reset aborts any state, including a pending memory wait
    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= next_state;
    end

    // Next-state logic; mem_ready only matters in the memory-access states
    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:     next_state = mem_ready ? DECODE : FETCH;
            DECODE:    next_state = decode_target(opcode);
            MEM_ADDR:  next_state = (opcode == OP_LW) ? MEM_READ : (opcode == OP_SW) ? MEM_WRITE : FETCH;
            MEM_READ:  next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: next_state = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   next_state = ALU_WB;
            IMM_EXEC:  next_state = IMM_WB;
            default:   next_state = FETCH;
        endcase
    end

    // Output decode from state; everything held low while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        zero_ext      = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = (decode_target(opcode) == FETCH);
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                MEM_WRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_R_FORMAT;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OP_ORI) ? ALU_ORI : ALU_ADD;
                    zero_ext  = (opcode == OP_ORI);
                end
                IMM_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving directed instruction sequences
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    typedef struct packed {
        logic [31:0] tag;
        logic [21:0] exp;
    } item_t;
    item_t sb[$];

    // Field order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
    // mem_to_reg reg_dst reg_write alu_src_a | alu_src_b | alu_op | pc_source | zero_ext illegal_op
    localparam logic [17:0] O_FETCH_RDY = 18'b1001010000_01_00_00_00;
    localparam logic [17:0] O_FETCH_WT  = 18'b0001000000_01_00_00_00;
    localparam logic [17:0] O_DECODE    = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] O_DECODE_IL = 18'b0000000000_11_00_00_01;
    localparam logic [17:0] O_MEM_ADDR  = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] O_MEM_READ  = 18'b0011000000_00_00_00_00;
    localparam logic [17:0] O_MEM_WRITE = 18'b0010100000_00_00_00_00;
    localparam logic [17:0] O_MEM_WB    = 18'b0000001010_00_00_00_00;
    localparam logic [17:0] O_EXECUTE   = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] O_ALU_WB    = 18'b0000000110_00_00_00_00;
    localparam logic [17:0] O_BRANCH    = 18'b0100000001_00_01_01_00;
    localparam logic [17:0] O_JUMP      = 18'b1000000000_00_00_10_00;
    localparam logic [17:0] O_ORI_EXEC  = 18'b0000000001_10_11_00_10;
    localparam logic [17:0] O_ADDI_EXEC = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] O_IMM_WB    = 18'b0000000010_00_00_00_00;
    localparam logic [17:0] O_ZERO      = 18'b0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .zero_ext(zero_ext), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [17:0] outs);
        item_t it;
        @(posedge clk);
        #1;
        reset = rst;
        opcode = op;
        mem_ready = mr;
        step_no++;
        it.tag = step_no;
        it.exp = {st, outs};
        sb.push_back(it);
    endtask

    // Monitor: compare the presented outputs against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [21:0] got;
            it = sb.pop_front();
            got = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, zero_ext, illegal_op};
            checks++;
            if (got !== it.exp) begin
                failures++;
                $display("FAIL step%0d state/outputs got=%b expected=%b", it.tag, got, it.exp);
            end
            if (mem_read && mem_write) begin
                failures++;
                $display("FAIL step%0d mem_read and mem_write both high", it.tag);
            end
        end
    end

    initial begin
        // Reset: state already FETCH after first edge, all outputs low
        step(1, 6'h00, 1, 4'd0, O_ZERO);
        // R-type: 0,1,6,7,0 (mem_ready high in non-memory states is ignored)
        step(0, 6'h00, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h00, 1, 4'd1, O_DECODE);
        step(0, 6'h00, 1, 4'd6, O_EXECUTE);
        step(0, 6'h00, 1, 4'd7, O_ALU_WB);
        // lw with one fetch wait and three MEM_READ waits
        step(0, 6'h23, 0, 4'd0, O_FETCH_WT);
        step(0, 6'h23, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h23, 0, 4'd1, O_DECODE);
        step(0, 6'h23, 0, 4'd2, O_MEM_ADDR);
        step(0, 6'h23, 0, 4'd3, O_MEM_READ);
        step(0, 6'h23, 0, 4'd3, O_MEM_READ);
        step(0, 6'h23, 0, 4'd3, O_MEM_READ);
        step(0, 6'h23, 1, 4'd3, O_MEM_READ);
        step(0, 6'h23, 0, 4'd4, O_MEM_WB);
        // ori
        step(0, 6'h0D, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h0D, 0, 4'd1, O_DECODE);
        step(0, 6'h0D, 0, 4'd10, O_ORI_EXEC);
        step(0, 6'h0D, 0, 4'd11, O_IMM_WB);
        // addi
        step(0, 6'h08, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h08, 1, 4'd1, O_DECODE);
        step(0, 6'h08, 1, 4'd10, O_ADDI_EXEC);
        step(0, 6'h08, 1, 4'd11, O_IMM_WB);
        // illegal opcode: one-cycle pulse, back to FETCH
        step(0, 6'h3F, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h3F, 0, 4'd1, O_DECODE_IL);
        step(0, 6'h3F, 0, 4'd0, O_FETCH_WT);
        // beq
        step(0, 6'h04, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h04, 0, 4'd1, O_DECODE);
        step(0, 6'h04, 0, 4'd8, O_BRANCH);
        // j
        step(0, 6'h02, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h02, 0, 4'd1, O_DECODE);
        step(0, 6'h02, 0, 4'd9, O_JUMP);
        // sw completing with zero wait
        step(0, 6'h2B, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h2B, 0, 4'd1, O_DECODE);
        step(0, 6'h2B, 0, 4'd2, O_MEM_ADDR);
        step(0, 6'h2B, 1, 4'd5, O_MEM_WRITE);
        // sw aborted by reset while waiting in MEM_WRITE
        step(0, 6'h2B, 1, 4'd0, O_FETCH_RDY);
        step(0, 6'h2B, 0, 4'd1, O_DECODE);
        step(0, 6'h2B, 0, 4'd2, O_MEM_ADDR);
        step(0, 6'h2B, 0, 4'd5, O_MEM_WRITE);
        step(1, 6'h2B, 0, 4'd5, O_ZERO);
        step(0, 6'h2B, 0, 4'd0, O_FETCH_WT);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
